sort_stream_collector: RTL and testbench

//  Receive end of the merge sorter's serial output stream (SortOut/OutValid).

---
 rtl/sort_stream_collector.sv | 132 +++++++++++++
 tb/tb_sort_stream_collector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_collector.sv
// Collects the merge sorter's serial output into 4-lane words, flags order violations per block,
// and buffers the words in a FIFO presented on a valid/ready interface.
module sort_stream_collector #(
  parameter int unsigned DW      = 8,
  parameter int unsigned BLK_LEN = 32,
  parameter int unsigned DEPTH   = 8,
  parameter bit          DESCEND = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  input  logic                     blk_abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_d0,
  output logic [DW-1:0]            out_d1,
  output logic [DW-1:0]            out_d2,
  output logic [DW-1:0]            out_d3,
  output logic                     out_last,
  output logic                     out_err,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned SW = $clog2(BLK_LEN);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = 4 * DW + 2;

  logic [1:0]          lane_q, lane_d;
  logic [SW-1:0]       samp_q, samp_d;
  logic [DW-1:0]       prev_q, prev_d;
  logic [2:0][DW-1:0]  lanes_q, lanes_d;
  logic                err_acc_q, err_acc_d;
  logic                viol, blk_end, push;
  logic [WW-1:0]       push_word;

  logic [WW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                full, pop, wr_en;
  logic [WW-1:0]       head;

  assign blk_end = (samp_q == SW'(BLK_LEN - 1));
  // Sample index 0 opens a block, so it is never compared against the previous one.
  assign viol = (samp_q != '0) &&
                (DESCEND ? ($signed(in_data) > $signed(prev_q))
                         : ($signed(in_data) < $signed(prev_q)));
  // Word layout: {err, last, d3, d2, d1, d0}.
  assign push_word = {err_acc_q | viol, blk_end, in_data, lanes_q[2], lanes_q[1], lanes_q[0]};

  always_comb begin
    lane_d    = lane_q;
    samp_d    = samp_q;
    prev_d    = prev_q;
    lanes_d   = lanes_q;
    err_acc_d = err_acc_q;
    push      = 1'b0;
    if (blk_abort) begin
      lane_d    = '0;
      samp_d    = '0;
      err_acc_d = 1'b0;
    end else if (in_valid) begin
      prev_d = in_data;
      lane_d = lane_q + 2'd1;
      samp_d = blk_end ? '0 : samp_q + SW'(1);
      if (lane_q == 2'd3) begin
        push      = 1'b1;
        err_acc_d = 1'b0;
      end else begin
        lanes_d[lane_q] = in_data;
        err_acc_d       = err_acc_q | viol;
      end
    end
  end

  assign full  = (cnt_q == (AW + 1)'(DEPTH));
  assign pop   = (cnt_q != '0) && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    wptr_d = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    ovf_d  = ovf_q | (push && !wr_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q    <= '0;
      samp_q    <= '0;
      prev_q    <= '0;
      lanes_q   <= '0;
      err_acc_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      samp_q    <= samp_d;
      prev_q    <= prev_d;
      lanes_q   <= lanes_d;
      err_acc_q <= err_acc_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  // Head data is gated so every output reads zero while nothing is buffered.
  assign out_valid = (cnt_q != '0);
  assign head      = out_valid ? mem_q[rptr_q] : '0;
  assign out_d0    = head[DW-1:0];
  assign out_d1    = head[2*DW-1:DW];
  assign out_d2    = head[3*DW-1:2*DW];
  assign out_d3    = head[4*DW-1:3*DW];
  assign out_last  = head[4*DW];
  assign out_err   = head[4*DW+1];
  assign ovf       = ovf_q;
  assign level     = cnt_q;

endmodule

// File: tb/tb_sort_stream_collector.sv
// Bench for sort_stream_collector: directed scenarios plus random traffic, all checked every
// cycle against a queue-based model of the packed-word stream.
module tb_sort_stream_collector;

  localparam int unsigned DW      = 8;
  localparam int unsigned BLK_LEN = 32;
  localparam int unsigned DEPTH   = 8;
  localparam bit          DESCEND = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          blk_abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_last, out_err, ovf;
  logic [DW-1:0] out_d0, out_d1, out_d2, out_d3;
  logic [$clog2(DEPTH):0] level;

  int n_checks = 0;
  int n_fail   = 0;

  sort_stream_collector #(
    .DW(DW), .BLK_LEN(BLK_LEN), .DEPTH(DEPTH), .DESCEND(DESCEND)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .blk_abort(blk_abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .out_last(out_last), .out_err(out_err), .ovf(ovf), .level(level)
  );

  always #5 clk = ~clk;

  // Model: FIFO of whole words, samples gathered in a list until four are present.
  typedef struct {
    logic [3:0][DW-1:0] d;
    bit                 last;
    bit                 err;
  } word_t;

  word_t                mq[$];
  logic [DW-1:0]        pend[$];
  bit                   pend_err = 0;
  int                   sidx = 0;
  logic signed [DW-1:0] mprev = '0;
  bit                   movf = 0;
  bit                   started = 0;
  bit                   m_pop, m_have;
  int                   m_n0;
  word_t                m_w;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      pend.delete();
      pend_err = 0;
      sidx     = 0;
      movf     = 0;
      started  = 1;
    end else begin
      m_n0   = mq.size();
      m_pop  = (m_n0 > 0) && out_ready;
      m_have = 0;
      if (blk_abort) begin
        pend.delete();
        pend_err = 0;
        sidx     = 0;
      end else if (in_valid) begin
        if (sidx != 0) begin
          if (DESCEND ? ($signed(in_data) > mprev) : ($signed(in_data) < mprev)) pend_err = 1;
        end
        mprev = in_data;
        pend.push_back(in_data);
        if (pend.size() == 4) begin
          for (int k = 0; k < 4; k++) m_w.d[k] = pend[k];
          m_w.err  = pend_err;
          m_w.last = (sidx == BLK_LEN - 1);
          m_have   = 1;
          pend.delete();
          pend_err = 0;
        end
        sidx = (sidx + 1) % BLK_LEN;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_have) begin
        if (m_n0 == DEPTH && !m_pop) movf = 1;
        else mq.push_back(m_w);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      if (out_valid !== (mq.size() != 0) || level !== mq.size() || ovf !== movf) begin
        n_fail++;
        $display("FAIL status t=%0t: got valid=%0b level=%0d ovf=%0b, want valid=%0b level=%0d ovf=%0b",
                 $time, out_valid, level, ovf, mq.size() != 0, mq.size(), movf);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if ({out_d3, out_d2, out_d1, out_d0} !== mq[0].d || out_last !== mq[0].last ||
            out_err !== mq[0].err) begin
          n_fail++;
          $display("FAIL word t=%0t: got d=%h last=%0b err=%0b, want d=%h last=%0b err=%0b",
                   $time, {out_d3, out_d2, out_d1, out_d0}, out_last, out_err,
                   mq[0].d, mq[0].last, mq[0].err);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_data  = DW'(v);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int v;
  int rv;

  initial begin
    do_reset();
    chk("reset_level", int'(level), 0);
    chk("reset_valid", int'(out_valid), 0);

    // T1: one ascending block
    for (int i = 0; i < 32; i++) send(i - 16);
    chk("t1_level", int'(level), 8);
    chk("t1_d0", int'($signed(out_d0)), -16);
    chk("t1_d1", int'($signed(out_d1)), -15);
    chk("t1_d3", int'($signed(out_d3)), -13);
    chk("t1_last_w1", int'(out_last), 0);
    pop_n(7);
    chk("t1_last_w8", int'(out_last), 1);
    chk("t1_d3_w8", int'($signed(out_d3)), 15);
    pop_n(1);
    chk("t1_drained", int'(out_valid), 0);

    // T2: samples 9,10 = 5,3 break the order inside word 3
    for (int i = 0; i < 32; i++) begin
      v = (i == 9) ? 5 : (i == 10) ? 3 : i - 16;
      send(v);
    end
    pop_n(2);
    chk("t2_err_w3", int'(out_err), 1);
    chk("t2_d1_w3", int'($signed(out_d1)), 5);
    pop_n(1);
    chk("t2_err_w4", int'(out_err), 0);
    pop_n(5);

    // T3: nine words into an eight-deep FIFO
    for (int i = 0; i < 36; i++) send(i - 16);
    chk("t3_level", int'(level), 8);
    chk("t3_ovf", int'(ovf), 1);
    chk("t3_head", int'($signed(out_d0)), -16);
    pop_n(1);
    chk("t3_second", int'($signed(out_d0)), -12);
    pop_n(7);
    chk("t3_empty", int'(level), 0);

    // T6: reset with two words buffered and three samples pending
    for (int i = 0; i < 11; i++) send(i + 10);
    chk("t6_level_pre", int'(level), 2);
    do_reset();
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_ovf", int'(ovf), 0);
    for (int i = 1; i <= 4; i++) send(i);
    chk("t6_level", int'(level), 1);
    chk("t6_d0", int'($signed(out_d0)), 1);
    chk("t6_d3", int'($signed(out_d3)), 4);
    pop_n(1);

    // T4: simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 35; i++) send(i - 16);
    out_ready = 1'b1;
    send(19);
    out_ready = 1'b0;
    chk("t4_level", int'(level), 8);
    chk("t4_ovf", int'(ovf), 0);
    chk("t4_head", int'($signed(out_d0)), -12);
    pop_n(8);

    // T5: abort after six samples, then a fresh block
    do_reset();
    for (int i = 0; i < 6; i++) send(50 + i);
    blk_abort = 1'b1;
    out_ready = 1'b1;
    send(-128);
    blk_abort = 1'b0;
    out_ready = 1'b0;
    chk("t5_level_abort", int'(level), 0);
    for (int i = 0; i < 32; i++) send(i - 16);
    chk("t5_level", int'(level), 8);
    chk("t5_d0", int'($signed(out_d0)), -16);
    chk("t5_err", int'(out_err), 0);
    pop_n(7);
    chk("t5_last", int'(out_last), 1);
    pop_n(1);

    // Random traffic: mostly ascending data with occasional jumps, aborts, stalls and resets
    do_reset();
    rv = 0;
    for (int c = 0; c < 4000; c++) begin
      rv = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : rv + int'($urandom_range(0, 2));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'(rv);
      blk_abort = ($urandom_range(0, 99) == 0);
      out_ready = (c % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    in_valid  = 1'b0;
    blk_abort = 1'b0;
    rst       = 1'b0;
    pop_n(DEPTH + 1);
    chk("final_empty", int'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
